// File: rtl/enc_rr.sv
// N-to-log2(N) request encoder with registered result, valid/ready handshake
// and either fixed-priority (lowest index) or round-robin selection.
module enc_rr #(
    parameter  int N    = 8,
    parameter  int MODE = 0,
    localparam int W    = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] in,
    output logic         in_ready,
    output logic [W-1:0] out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         multi
);

    logic [W-1:0] r_out;
    logic         r_valid;
    logic         r_multi;
    logic [W-1:0] r_ptr;

    logic [W-1:0] w_sel;
    logic [W-1:0] w_ptr_nxt;
    logic         w_multi;
    logic         w_accept;
    logic         w_consume;

    // Wrap a pointer-relative offset back into 0..N-1 without a modulo.
    function automatic int unsigned wrap_idx(input int unsigned base, input int unsigned off);
        int unsigned sum;
        sum = base + off;
        return (sum >= N) ? sum - N : sum;
    endfunction

    always_comb begin
        w_sel = '0;
        if (MODE == 0) begin
            for (int unsigned i = N; i > 0; i--) begin
                if (in[i-1]) w_sel = W'(i - 1);
            end
        end else begin
            // Scan downward so the first hit at/after r_ptr is the last write.
            for (int unsigned k = N; k > 0; k--) begin
                if (in[wrap_idx(32'(r_ptr), k - 1)]) w_sel = W'(wrap_idx(32'(r_ptr), k - 1));
            end
        end
    end

    assign w_ptr_nxt = (w_sel == W'(N - 1)) ? '0 : w_sel + W'(1);
    assign w_multi   = |(in & (in - N'(1)));
    assign in_ready  = !r_valid || out_ready;
    assign w_accept  = en && in_ready && (|in);
    assign w_consume = r_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out   <= '0;
            r_valid <= 1'b0;
            r_multi <= 1'b0;
            r_ptr   <= '0;
        end else if (w_accept) begin
            r_out   <= w_sel;
            r_multi <= w_multi;
            r_valid <= 1'b1;
            if (MODE != 0) r_ptr <= w_ptr_nxt;
        end else if (w_consume) begin
            r_valid <= 1'b0;
        end
    end

    assign out       = r_out;
    assign out_valid = r_valid;
    assign multi     = r_multi;

endmodule

// File: tb/tb_enc_rr.sv
// Self-checking bench for enc_rr: three instances (N=8 fixed, N=8 round-robin,
// N=5 round-robin) compared against a behavioural model of the selection rules.
module tb_enc_rr;

    logic       clk = 1'b0;
    logic       rst, en, ordy;
    logic [7:0] in8;
    logic [4:0] in5;

    logic       ir0, ir1, ir2, v0, v1, v2, m0, m1, m2;
    logic [2:0] o0, o1, o2;

    always #5 clk = ~clk;

    enc_rr #(.N(8), .MODE(0)) u0 (
        .clk(clk), .rst(rst), .en(en), .in(in8), .in_ready(ir0),
        .out(o0), .out_valid(v0), .out_ready(ordy), .multi(m0)
    );
    enc_rr #(.N(8), .MODE(1)) u1 (
        .clk(clk), .rst(rst), .en(en), .in(in8), .in_ready(ir1),
        .out(o1), .out_valid(v1), .out_ready(ordy), .multi(m1)
    );
    enc_rr #(.N(5), .MODE(1)) u2 (
        .clk(clk), .rst(rst), .en(en), .in(in5), .in_ready(ir2),
        .out(o2), .out_valid(v2), .out_ready(ordy), .multi(m2)
    );

    logic       ov[3], om[3], oir[3];
    logic [2:0] oo[3], op[3];
    assign ov[0] = v0;   assign ov[1] = v1;   assign ov[2] = v2;
    assign om[0] = m0;   assign om[1] = m1;   assign om[2] = m2;
    assign oir[0] = ir0; assign oir[1] = ir1; assign oir[2] = ir2;
    assign oo[0] = o0;   assign oo[1] = o1;   assign oo[2] = o2;
    assign op[0] = '0;   assign op[1] = u1.r_ptr; assign op[2] = u2.r_ptr;

    int total = 0;
    int bad   = 0;

    int mn[3]    = '{8, 8, 5};
    int mmode[3] = '{0, 1, 1};
    bit mv[3];
    int mo[3];
    bit mm[3];
    int mp[3];

    int rr_seq[6] = '{0, 2, 7, 0, 2, 7};
    int p_saved;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] req_of(input int i);
        return (i < 2) ? 32'(in8) : 32'(in5);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mv[i] = 1'b0; mo[i] = 0; mm[i] = 1'b0; mp[i] = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            logic [31:0] r;
            bit          acc;
            int          sel;
            r   = req_of(i);
            acc = en && (!mv[i] || ordy) && (r != 0);
            if (acc) begin
                sel = -1;
                for (int k = 0; k < mn[i]; k++) begin
                    int j;
                    j = (mmode[i] == 0) ? k : (mp[i] + k) % mn[i];
                    if (sel < 0 && r[j]) sel = j;
                end
                mo[i] = sel;
                mm[i] = ($countones(r) > 1);
                mv[i] = 1'b1;
                if (mmode[i] == 1) mp[i] = (sel + 1) % mn[i];
            end else if (mv[i] && ordy) begin
                mv[i] = 1'b0;
            end
        end
    endtask

    // One clock: check in_ready before the edge, advance model, check after.
    task automatic cyc(input string tag);
        #1;
        for (int i = 0; i < 3; i++)
            chk($sformatf("%s.in_ready%0d", tag, i), 32'(oir[i]), 32'(!mv[i] || ordy));
        model_step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s.valid%0d", tag, i), 32'(ov[i]), 32'(mv[i]));
            chk($sformatf("%s.out%0d", tag, i), 32'(oo[i]), 32'(mo[i]));
            chk($sformatf("%s.multi%0d", tag, i), 32'(om[i]), 32'(mm[i]));
            if (i > 0) chk($sformatf("%s.ptr%0d", tag, i), 32'(op[i]), 32'(mp[i]));
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; ordy = 1'b0; in8 = '0; in5 = '0;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst.valid%0d", i), 32'(ov[i]), 0);
            chk($sformatf("rst.out%0d", i), 32'(oo[i]), 0);
            chk($sformatf("rst.in_ready%0d", i), 32'(oir[i]), 1);
        end
        @(negedge clk);
        rst = 1'b0;

        // fixed priority
        en = 1'b1; ordy = 1'b1; in8 = 8'b0010_1000;
        cyc("fp1");
        chk("fp1.o", 32'(o0), 3); chk("fp1.m", 32'(m0), 1);
        in8 = 8'b1000_0000;
        cyc("fp2");
        chk("fp2.o", 32'(o0), 7); chk("fp2.m", 32'(m0), 0);
        in8 = '0;
        cyc("fp3");
        chk("fp3.v", 32'(v0), 0);

        // round-robin wrap 7 -> 0
        in8 = 8'b1000_0101;
        for (int k = 0; k < 6; k++) begin
            cyc("rr");
            chk($sformatf("rr.seq%0d", k), 32'(o1), 32'(rr_seq[k]));
            chk($sformatf("rr.v%0d", k), 32'(v1), 1);
        end

        // non-power-of-two round-robin
        in8 = '0; in5 = 5'b10001;
        for (int k = 0; k < 4; k++) begin
            cyc("n5");
            chk($sformatf("n5.seq%0d", k), 32'(o2), (k % 2 == 0) ? 0 : 4);
        end

        // backpressure
        in5 = '0; in8 = 8'h10;
        cyc("bp0");
        chk("bp0.o1", 32'(o1), 4);
        ordy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in8 = 8'($urandom);
            cyc("bp");
            chk($sformatf("bp.hold%0d", k), 32'(o1), 4);
            chk($sformatf("bp.ir%0d", k), 32'(ir1), 0);
        end
        ordy = 1'b1; in8 = 8'h06;
        cyc("bp_rel");
        chk("bp_rel.o0", 32'(o0), 1);

        // enable gating
        in8 = '0;
        cyc("en_drain");
        en = 1'b0; in8 = 8'hFF; in5 = 5'h1F;
        cyc("en_off0");
        cyc("en_off1");
        chk("en_off.v1", 32'(v1), 0);
        p_saved = mp[1];
        en = 1'b1;
        cyc("en_on");
        chk("en_on.o0", 32'(o0), 0);
        chk("en_on.o1", 32'(o1), 32'(p_saved));
        chk("en_on.m1", 32'(m1), 1);

        // asynchronous reset while holding out=5
        in8 = 8'h20; in5 = '0;
        cyc("pre_rst");
        chk("pre_rst.o1", 32'(o1), 5);
        ordy = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("arst.valid%0d", i), 32'(ov[i]), 0);
            chk($sformatf("arst.out%0d", i), 32'(oo[i]), 0);
            chk($sformatf("arst.multi%0d", i), 32'(om[i]), 0);
            chk($sformatf("arst.in_ready%0d", i), 32'(oir[i]), 1);
        end
        chk("arst.ptr1", 32'(op[1]), 0);
        @(negedge clk);
        rst = 1'b0; ordy = 1'b1; in8 = 8'hFF;
        cyc("post_rst");
        chk("post_rst.o1", 32'(o1), 0);

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            en   = ($urandom_range(0, 7) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            in8  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom & $urandom);
            in5  = ($urandom_range(0, 5) == 0) ? 5'h00 : 5'($urandom & $urandom);
            cyc("rnd");
            chk("rnd.range2", 32'(o2 <= 3'd4), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
